approx_log_divider: RTL and testbench

Mitchell-style approximate signed divider, the inverse-direction companion of `approx_log_multiplier`. It converts |A| and |B| to truncated base-2 logarithms and subtracts them. The difference is converted back to a fixed-point quotient through a 3-stage valid/ready pipeline. It shares the leading-one/log front end and the `T`-bit mantissa truncation with the multiplier, so the same error-bracket benches apply.

---
 rtl/approx_log_divider_pkg.sv | 41 ++++
 rtl/approx_log_divider_if.sv | 30 +++
 rtl/approx_log_divider_log_encoder.sv | 28 ++
 rtl/approx_log_divider.sv | 116 +++++++++++
 tb/tb_approx_log_divider.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/approx_log_divider_pkg.sv
// approx_log_pkg: shared definitions for the Mitchell-style approximate divider
// (and its multiplier companion).
//   T_DEF / FRAC_DEF : default log-mantissa bits and quotient fraction bits
//   log_t            : truncated base-2 log (3-bit characteristic, T-bit fraction)
//   s1_t / s2_t      : pipeline stage register layouts
//   QMAX             : saturation magnitude 2^(QW-1)-1 for the default width
package approx_log_pkg;

   localparam int unsigned T_DEF    = 4;
   localparam int unsigned FRAC_DEF = 8;
   localparam int unsigned QW_DEF   = 9 + FRAC_DEF;

   function automatic logic [31:0] qmax_fn(input int unsigned qw);
      return (32'd1 << (qw - 1)) - 32'd1;
   endfunction

   localparam logic [QW_DEF-1:0] QMAX = QW_DEF'(qmax_fn(QW_DEF));

   typedef struct packed {
      logic [2:0]       k;
      logic [T_DEF-1:0] frac;
   } log_t;

   typedef struct packed {
      logic [7:0] abs_a;
      logic [7:0] abs_b;
      logic       sign;
      logic       a_zero;
      logic       b_zero;
   } s1_t;

   // kq is a two's-complement characteristic difference in -8..7.
   typedef struct packed {
      logic [3:0]       kq;
      logic [T_DEF-1:0] f;
      logic             sign;
      logic             a_zero;
      logic             b_zero;
   } s2_t;

endpackage

// File: rtl/approx_log_divider_if.sv
// approx_log_divider_if: operand/result valid-ready bundle.
//   in_valid/in_ready/A/B                     : operand channel (master -> slave)
//   out_valid/out_ready/quotient/div_by_zero  : result channel (slave -> master)
// quotient is signed Q9.FRAC, width 9+FRAC.
interface approx_log_divider_if
   import approx_log_pkg::*;
#(
   parameter int unsigned FRAC = FRAC_DEF
);
   localparam int unsigned QW = 9 + FRAC;

   logic          in_valid;
   logic          in_ready;
   logic [7:0]    A;
   logic [7:0]    B;
   logic          out_valid;
   logic          out_ready;
   logic [QW-1:0] quotient;
   logic          div_by_zero;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, quotient, div_by_zero
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, quotient, div_by_zero
   );
endinterface

// File: rtl/approx_log_divider_log_encoder.sv
// log_encoder: combinational truncated base-2 log of an 8-bit unsigned value.
//   i_val : operand (non-zero for a meaningful result)
//   o_k   : position of the leading one
//   o_xt  : top T bits of the bits below the leading one, left-aligned,
//           zero-padded when fewer than T such bits exist
module log_encoder
   import approx_log_pkg::*;
#(
   parameter int unsigned T = T_DEF
) (
   input  logic [7:0]   i_val,
   output logic [2:0]   o_k,
   output logic [T-1:0] o_xt
);
   logic [6:0] w_x;

   always_comb begin
      o_k = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i_val[i]) o_k = 3'(i);
      end
   end

   // Normalising shift pushes the leading one out of the 7-bit window, leaving
   // the fraction left-aligned with zero fill below it.
   assign w_x  = 7'(i_val << (3'd7 - o_k));
   assign o_xt = T'(w_x >> (7 - T));
endmodule

// File: rtl/approx_log_divider.sv
// approx_log_divider: 3-stage Mitchell approximate signed divider A/B.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : in_valid/in_ready/A/B operands, out_valid/out_ready/
//                     quotient (signed Q9.FRAC)/div_by_zero results
//   op_count        : accepted inputs (APPROX_DIV_STATS_EN only)
//   dbz_count       : transferred divide-by-zero results (APPROX_DIV_STATS_EN only)
// Optional statistics counters are enabled by defining APPROX_DIV_STATS_EN.
module approx_log_divider
   import approx_log_pkg::*;
#(
   parameter int unsigned T    = T_DEF,
   parameter int unsigned FRAC = FRAC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   approx_log_divider_if.slave bus
`ifdef APPROX_DIV_STATS_EN
   ,
   output logic [15:0]         op_count,
   output logic [15:0]         dbz_count
`endif
);
   localparam int unsigned   QW      = 9 + FRAC;
   localparam logic [QW-1:0] LP_QMAX = QW'(qmax_fn(QW));

   logic          w_advance, w_accept;
   logic          r_v1, r_v2, r_v3;
   s1_t           r_s1, w_s1;
   s2_t           r_s2, w_s2;
   logic [QW-1:0] r_q, w_q, w_mag;
   logic          r_dbz;
   logic [2:0]    w_k1, w_k2;
   logic [T-1:0]  w_xt1, w_xt2;
   logic [3:0]    w_kd;
   logic [T:0]    w_fd;
   int            w_sh;

   // Single global advance: bubbles are never collapsed.
   assign w_advance = !r_v3 || bus.out_ready;
   assign w_accept  = bus.in_valid && w_advance;

   assign bus.in_ready    = w_advance;
   assign bus.out_valid   = r_v3;
   assign bus.quotient    = r_q;
   assign bus.div_by_zero = r_dbz;

   // S1: magnitudes (128 stays representable as unsigned) and flags
   always_comb begin
      w_s1        = '0;
      w_s1.abs_a  = bus.A[7] ? -bus.A : bus.A;
      w_s1.abs_b  = bus.B[7] ? -bus.B : bus.B;
      w_s1.sign   = bus.A[7] ^ bus.B[7];
      w_s1.a_zero = (bus.A == '0);
      w_s1.b_zero = (bus.B == '0);
   end

   // S2: log difference; a fraction borrow moves one unit into the characteristic
   log_encoder #(.T(T)) u_log_a (.i_val(r_s1.abs_a), .o_k(w_k1), .o_xt(w_xt1));
   log_encoder #(.T(T)) u_log_b (.i_val(r_s1.abs_b), .o_k(w_k2), .o_xt(w_xt2));

   always_comb begin
      w_kd        = {1'b0, w_k1} - {1'b0, w_k2};
      w_fd        = {1'b0, w_xt1} - {1'b0, w_xt2};
      w_s2        = '0;
      w_s2.kq     = w_fd[T] ? (w_kd - 4'd1) : w_kd;
      w_s2.f      = w_fd[T-1:0];
      w_s2.sign   = r_s1.sign;
      w_s2.a_zero = r_s1.a_zero;
      w_s2.b_zero = r_s1.b_zero;
   end

   // S3: antilog (1.f scaled by 2^(kq+FRAC-T)), sign, and special cases
   always_comb begin
      w_sh = int'($signed(r_s2.kq)) + int'(FRAC) - int'(T);
      if (w_sh >= 0) w_mag = QW'({1'b1, r_s2.f}) << w_sh;
      else           w_mag = QW'({1'b1, r_s2.f}) >> (-w_sh);
      if (r_s2.a_zero)      w_q = '0;
      else if (r_s2.b_zero) w_q = r_s2.sign ? -LP_QMAX : LP_QMAX;
      else                  w_q = r_s2.sign ? -w_mag : w_mag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_q   <= '0;
         r_dbz <= 1'b0;
      end else if (w_advance) begin
         r_v1 <= bus.in_valid;
         if (bus.in_valid) r_s1 <= w_s1;
         r_v2  <= r_v1;
         r_s2  <= w_s2;
         r_v3  <= r_v2;
         r_q   <= w_q;
         r_dbz <= r_s2.b_zero;
      end
   end

`ifdef APPROX_DIV_STATS_EN
   logic [15:0] r_op_cnt, r_dbz_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op_cnt  <= '0;
         r_dbz_cnt <= '0;
      end else begin
         if (w_accept) r_op_cnt <= r_op_cnt + 16'd1;
         if (r_v3 && bus.out_ready && r_dbz) r_dbz_cnt <= r_dbz_cnt + 16'd1;
      end
   end

   assign op_count  = r_op_cnt;
   assign dbz_count = r_dbz_cnt;
`endif
endmodule

// File: tb/tb_approx_log_divider.sv
// Self-checking bench for approx_log_divider (T=4, FRAC=8, QW=17).
module tb_approx_log_divider;
   localparam int unsigned TT = 4;
   localparam int unsigned FF = 8;
   localparam int          QMAX_TB = 65535;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   approx_log_divider_if #(.FRAC(FF)) bus ();

`ifdef APPROX_DIV_STATS_EN
   logic [15:0] op_count, dbz_count;
   approx_log_divider #(.T(TT), .FRAC(FF)) dut (
      .clk(clk), .rst(rst), .bus(bus), .op_count(op_count), .dbz_count(dbz_count));
`else
   approx_log_divider #(.T(TT), .FRAC(FF)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   int          n_checks = 0;
   int          n_err    = 0;
   logic [17:0] sb[$];    // {div_by_zero, quotient}

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Independent reference: integer log2, fraction via scaled integer division.
   function automatic logic [17:0] model(input int a, input int b);
      int aa, bb, k1, k2, x1, x2, kq, f, e, mag, q;
      bit s, dbz;
      aa = (a < 0) ? -a : a;
      bb = (b < 0) ? -b : b;
      s  = (a < 0) != (b < 0);
      dbz = 1'b0;
      if (bb == 0) begin
         dbz = 1'b1;
         q = (aa == 0) ? 0 : (s ? -QMAX_TB : QMAX_TB);
      end else if (aa == 0) begin
         q = 0;
      end else begin
         k1 = 0; while ((2 << k1) <= aa) k1++;
         k2 = 0; while ((2 << k2) <= bb) k2++;
         x1 = ((aa - (1 << k1)) * (1 << TT)) / (1 << k1);
         x2 = ((bb - (1 << k2)) * (1 << TT)) / (1 << k2);
         kq = k1 - k2;
         f  = x1 - x2;
         if (f < 0) begin kq--; f += (1 << TT); end
         e   = kq + FF - TT;
         mag = (e >= 0) ? (((1 << TT) + f) << e) : (((1 << TT) + f) >> (-e));
         q   = s ? -mag : mag;
      end
      return {dbz, 17'(q)};
   endfunction

   // Present a pair and hold it until accepted; the expectation is queued at acceptance.
   task automatic send(input int a, input int b, input logic [17:0] exp);
      logic acc;
      bus.in_valid = 1'b1;
      bus.A = 8'(a);
      bus.B = 8'(b);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            sb.push_back(exp);
            return;
         end
      end
      check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_exp(input int a, input int b, input int q, input logic d);
      send(a, b, {d, 17'(q)});
   endtask

   task automatic send_model(input int a, input int b);
      send(a, b, model(a, b));
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Output monitor: scoreboard pop on transfer, stall behaviour checks.
   logic        stalled_prev = 1'b0;
   logic [16:0] held_q;
   logic        held_d;
   logic [17:0] e;
   always @(negedge clk) begin
      if (rst) begin
         stalled_prev = 1'b0;
      end else begin
         if (bus.out_valid && !bus.out_ready) begin
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (stalled_prev) begin
               check("stall_hold_q", 32'(bus.quotient), 32'(held_q));
               check("stall_hold_dbz", 32'(bus.div_by_zero), 32'(held_d));
            end
            stalled_prev = 1'b1;
            held_q = bus.quotient;
            held_d = bus.div_by_zero;
         end else begin
            stalled_prev = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            check("unexpected_output", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("quotient", 32'(bus.quotient), 32'(e[16:0]));
               check("div_by_zero", 32'(bus.div_by_zero), 32'(e[17]));
            end
         end
      end
   end

   int bp_a[6] = '{100, -77, 3, 0, 127, -128};
   int bp_b[6] = '{7, 5, 0, 9, -3, 2};

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.A = '0;
      bus.B = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_quotient", 32'(bus.quotient), 32'd0);
      check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
`ifdef APPROX_DIV_STATS_EN
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_dbz_count", 32'(dbz_count), 32'd0);
`endif

      // Latency: the acceptance edge is the first of three register edges.
      send_exp(100, 7, 3712, 1'b0);
      bus.in_valid = 1'b0;
      check("lat_edge1", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_edge2", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_edge3", 32'(bus.out_valid), 32'd1);
      drain();

      // Exact power-of-two cases, back to back
      send_exp(64, 4, 4096, 1'b0);
      send_exp(-128, -1, 32768, 1'b0);
      send_exp(1, -128, -2, 1'b0);
      // Zero cases
      send_exp(5, 0, 65535, 1'b1);
      send_exp(-5, 0, -65535, 1'b1);
      send_exp(0, 0, 0, 1'b1);
      send_exp(0, 9, 0, 1'b0);
      bus.in_valid = 1'b0;
      drain();

      // Back-pressure: out_ready low for cycles 4..8
      fork
         begin
            for (int i = 0; i < 6; i++) send_model(bp_a[i], bp_b[i]);
            bus.in_valid = 1'b0;
         end
         begin
            for (int c = 1; c <= 12; c++) begin
               @(posedge clk); #1;
               bus.out_ready = (c < 4) || (c > 8);
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();

      // Mid-stream reset while stalled with three operations in flight
      bus.out_ready = 1'b0;
      send_model(20, 3);
      send_model(-90, 11);
      send_model(7, 0);
      bus.A = 8'd11;
      bus.B = 8'd3;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef APPROX_DIV_STATS_EN
      check("mrst_op_count", 32'(op_count), 32'd0);
      check("mrst_dbz_count", 32'(dbz_count), 32'd0);
`endif
      sb.delete();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("mrst_no_stale", 32'(bus.out_valid), 32'd0);

      // Full sweep of all operand pairs from a fresh reset
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int a = -128; a < 128; a++) begin
         for (int b = -128; b < 128; b++) send_model(a, b);
      end
      bus.in_valid = 1'b0;
      drain();
`ifdef APPROX_DIV_STATS_EN
      check("sweep_op_count", 32'(op_count), 32'd0);
      check("sweep_dbz_count", 32'(dbz_count), 32'd256);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
